// File: rtl/mult_arb.sv
// Round-robin front end that shares one variable-latency multiplier between two
// requesters, with a per-transaction timeout and a one-cycle recovery gap.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | multiplier stopped, arbitrating between req0 / req1
// S_RUN     | operands presented, m_start high, waiting for m_valid
// S_RECOVER | m_start low for one cycle so the multiplier reinitialises
module mult_arb #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [63:0] res,
    output logic        res_vld,
    output logic        res_id,
    output logic        res_err,
    output logic [31:0] m_mlier,
    output logic [31:0] m_mcand,
    output logic        m_start,
    input  logic [63:0] m_prodt,
    input  logic        m_valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    // TIMEOUT is at most 63, so six bits always hold the last RUN count
    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    logic [1:0] state;
    logic       ptr;
    logic       run_id;
    logic [5:0] run_cnt;

    logic       any_req;
    logic       win_id;
    logic       in_idle;
    logic       in_run;
    logic       grant;
    logic       done_ok;
    logic       done_to;
    logic       finish;

    assign any_req = req0 | req1;
    assign win_id  = (req0 & req1) ? ptr : req1;
    assign in_idle = (state == S_IDLE);
    assign in_run  = (state == S_RUN);
    assign grant   = in_idle & any_req;
    // a product arriving on the last allowed cycle still counts as a result
    assign done_ok = in_run & m_valid;
    assign done_to = in_run & ~m_valid & (run_cnt == CNT_LAST);
    assign finish  = done_ok | done_to;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (finish) begin
                        state <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr     <= 1'b0;
            run_id  <= 1'b0;
            m_mlier <= 32'd0;
            m_mcand <= 32'd0;
        end else if (grant) begin
            ptr     <= ~win_id;
            run_id  <= win_id;
            m_mlier <= win_id ? a1 : a0;
            m_mcand <= win_id ? b1 : b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_cnt <= 6'd0;
        end else if (grant) begin
            run_cnt <= 6'd0;
        end else if (in_run && !finish) begin
            run_cnt <= run_cnt + 6'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_start <= 1'b0;
        end else if (grant) begin
            m_start <= 1'b1;
        end else if (!in_run || finish) begin
            m_start <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
        end else begin
            gnt0 <= grant & ~win_id;
            gnt1 <= grant & win_id;
        end
    end

    // result fields only move on a completion so they hold between pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            res_vld <= 1'b0;
            res     <= 64'd0;
            res_id  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            res_vld <= finish;
            if (finish) begin
                res     <= done_ok ? m_prodt : 64'd0;
                res_id  <= run_id;
                res_err <= done_to;
            end
        end
    end

endmodule

// File: tb/tb_mult_arb.sv
// Bench for mult_arb: directed scenarios with literal expectations, then random
// traffic against a transaction-level model checked on every cycle.
module tb_mult_arb;
    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, res_vld, res_id, res_err, m_start;
    logic [63:0] res;
    logic [31:0] m_mlier, m_mcand;
    logic [63:0] m_prodt = '0;
    logic        m_valid = 1'b0;

    always #5 clock = ~clock;

    mult_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res(res), .res_vld(res_vld), .res_id(res_id), .res_err(res_err),
        .m_mlier(m_mlier), .m_mcand(m_mcand), .m_start(m_start),
        .m_prodt(m_prodt), .m_valid(m_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus controls
    bit rand_mode   = 0;
    bit spur_en     = 0;
    bit force_valid = 0;
    int lat         = 10;

    // ---------------- reference model (transaction level) ----------------
    int          cyc = 0;
    int          t_grant = 0;
    bit          mdl_busy = 0, mdl_recov = 0, mdl_ptr = 0, mdl_id = 0;
    logic        e_gnt0 = 0, e_gnt1 = 0, e_vld = 0, e_start = 0, e_id = 0, e_err = 0;
    logic [63:0] e_res = '0;
    logic [31:0] e_mlier = '0, e_mcand = '0;

    always @(posedge clock) begin
        bit w;
        bit fin;
        cyc++;
        e_gnt0 = 0; e_gnt1 = 0; e_vld = 0;
        fin = 0;
        if (reset) begin
            mdl_busy = 0; mdl_recov = 0; mdl_ptr = 0; mdl_id = 0;
            e_start = 0; e_mlier = '0; e_mcand = '0;
            e_res = '0; e_id = 0; e_err = 0;
        end else if (mdl_recov) begin
            mdl_recov = 0;
            e_start = 0;
        end else if (mdl_busy) begin
            if (m_valid) begin
                e_res = m_prodt; e_err = 0; fin = 1;
            end else if (cyc - t_grant == TIMEOUT) begin
                e_res = '0; e_err = 1; fin = 1;
            end
            if (fin) begin
                e_id = mdl_id; e_vld = 1; e_start = 0;
                mdl_busy = 0; mdl_recov = 1;
            end
        end else if (req0 || req1) begin
            w = (req0 && req1) ? mdl_ptr : req1;
            mdl_ptr = !w; mdl_id = w;
            e_mlier = w ? a1 : a0;
            e_mcand = w ? b1 : b0;
            e_gnt0 = !w; e_gnt1 = w;
            e_start = 1;
            mdl_busy = 1;
            t_grant = cyc;
        end
    end

    always @(negedge clock) begin
        if (cyc > 0) begin
            check("gnt0", gnt0, e_gnt0);
            check("gnt1", gnt1, e_gnt1);
            check("res_vld", res_vld, e_vld);
            check("m_start", m_start, e_start);
            check("m_mlier", m_mlier, e_mlier);
            check("m_mcand", m_mcand, e_mcand);
            check("res", res, e_res);
            check("res_id", res_id, e_id);
            check("res_err", res_err, e_err);
        end
    end

    // ---------------- behavioural multiplier ----------------
    int mcnt = 0;
    int cur_lat = 1;

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0: return TIMEOUT - 1;
            1: return TIMEOUT;
            2: return TIMEOUT + 1;
            3: return 500;
            default: return $urandom_range(1, 25);
        endcase
    endfunction

    always @(negedge clock) begin
        longint p;
        if (!m_start) begin
            mcnt = 0;
            m_valid = force_valid || (spur_en && $urandom_range(0, 3) == 0);
            m_prodt = {$urandom, $urandom};
        end else begin
            if (mcnt == 0) cur_lat = rand_mode ? pick_lat() : lat;
            mcnt++;
            if (mcnt == cur_lat) begin
                p = longint'($signed(m_mlier)) * longint'($signed(m_mcand));
                m_valid = 1'b1;
                m_prodt = p;
            end else begin
                m_valid = 1'b0;
                m_prodt = {$urandom, $urandom};
            end
        end
    end

    // ---------------- requesters ----------------
    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clock) begin
        if (gnt0) req0 = 1'b0;
        else if (rand_mode && !req0 && $urandom_range(0, 5) == 0) begin
            req0 = 1'b1; a0 = pick_op(); b0 = pick_op();
        end
        if (gnt1) req1 = 1'b0;
        else if (rand_mode && !req1 && $urandom_range(0, 5) == 0) begin
            req1 = 1'b1; a1 = pick_op(); b1 = pick_op();
        end
        if (rand_mode) reset = ($urandom_range(0, 1999) == 0);
    end

    // ---------------- directed helpers ----------------
    task automatic do_txn(input string tag, output int run_len, output bit [1:0] gmask);
        bit done;
        done = 0; run_len = 0; gmask = 2'b00;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            if (gnt0) gmask[0] = 1'b1;
            if (gnt1) gmask[1] = 1'b1;
            if (res_vld) done = 1;
            else if (m_start) run_len++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_wait: no res_vld within 300 cycles", tag);
        end
    endtask

    initial begin
        int rl;
        bit [1:0] gm;
        bit seen;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_res", res, 64'd0);
        check("rst_m_start", m_start, 1'b0);
        check("rst_gnt0", gnt0, 1'b0);
        reset = 1'b0;

        // basic product with a 10-cycle multiplier
        lat = 10; a0 = 32'd3; b0 = 32'd5; req0 = 1'b1;
        do_txn("t1", rl, gm);
        check("t1_res", res, 64'd15);
        check("t1_id", res_id, 1'b0);
        check("t1_err", res_err, 1'b0);
        check("t1_gnt", gm, 2'b01);
        check("t1_runlen", rl, 10);
        check("t1_recover_start", m_start, 1'b0);
        @(negedge clock);
        check("t1_idle_vld", res_vld, 1'b0);

        // round robin from a fresh reset
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        lat = 4;
        a0 = 32'hFFFF_FFFE; b0 = 32'd7; a1 = 32'd6; b1 = 32'hFFFF_FFFF;
        req0 = 1'b1; req1 = 1'b1;
        do_txn("t2a", rl, gm);
        check("t2a_res", res, 64'hFFFF_FFFF_FFFF_FFF2);
        check("t2a_id", res_id, 1'b0);
        do_txn("t2b", rl, gm);
        check("t2b_res", res, 64'hFFFF_FFFF_FFFF_FFFA);
        check("t2b_id", res_id, 1'b1);
        req0 = 1'b1; req1 = 1'b1;
        do_txn("t2c", rl, gm);
        check("t2c_id", res_id, 1'b0);
        do_txn("t2d", rl, gm);
        check("t2d_id", res_id, 1'b1);

        // early zero product from requester 1
        lat = 1; a1 = 32'd0; b1 = 32'd123; req1 = 1'b1;
        do_txn("t3", rl, gm);
        check("t3_res", res, 64'd0);
        check("t3_id", res_id, 1'b1);
        check("t3_err", res_err, 1'b0);
        check("t3_runlen", rl, 1);

        // valid on the very last allowed cycle still wins
        lat = TIMEOUT; a0 = 32'hFFFF_FFFD; b0 = 32'hFFFF_FFF5; req0 = 1'b1;
        do_txn("t4", rl, gm);
        check("t4_res", res, 64'd33);
        check("t4_err", res_err, 1'b0);
        check("t4_runlen", rl, TIMEOUT);

        // multiplier never answers
        lat = 1000; a0 = 32'd7; b0 = 32'd9; req0 = 1'b1;
        do_txn("t5", rl, gm);
        check("t5_res", res, 64'd0);
        check("t5_err", res_err, 1'b1);
        check("t5_id", res_id, 1'b0);
        check("t5_runlen", rl, TIMEOUT);
        @(negedge clock);
        check("t5_after_start", m_start, 1'b0);

        // reset five cycles into RUN
        lat = 1000; a0 = 32'd4; b0 = 32'd4; req0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (gnt0) seen = 1;
        end
        check("t6_gnt_seen", seen, 1'b1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_m_start", m_start, 1'b0);
        check("t6_vld", res_vld, 1'b0);
        check("t6_mlier", m_mlier, 32'd0);
        check("t6_err", res_err, 1'b0);
        reset = 1'b0;
        lat = 3; a0 = 32'd6; b0 = 32'd7; req0 = 1'b1;
        do_txn("t6", rl, gm);
        check("t6_res", res, 64'd42);
        check("t6_gnt", gm, 2'b01);

        // stray multiplier valids while idle
        repeat (2) @(negedge clock);
        force_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t7_vld", res_vld, 1'b0);
        end
        force_valid = 1'b0;
        check("t7_res", res, 64'd42);

        // random traffic, stray valids and occasional resets
        rand_mode = 1; spur_en = 1;
        repeat (15000) @(negedge clock);
        rand_mode = 0; spur_en = 0; reset = 1'b0;
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
